hall_call_arbiter: RTL and testbench



---
 rtl/elevator_pkg.sv | 38 +++
 rtl/hall_call_pick.sv | 60 ++++++
 rtl/hall_call_arbiter.sv | 135 +++++++++++++
 tb/tb_hall_call_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared elevator definitions: floor/direction encodings, arbiter FSM states and
// small floor arithmetic helpers used by the hall-call arbiter and the car controller.
package elevator_pkg;

    localparam int         NUM_FLOOR  = 7;
    localparam logic [1:0] UP         = 2'b10;
    localparam logic [1:0] DOWN       = 2'b01;
    localparam logic [1:0] DIR_IDLE   = 2'b00;
    localparam logic [2:0] FLOOR_NONE = 3'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_SERVE = 2'd2
    } arb_state_t;

    // An out-of-range car position (only 0 is encodable) is treated as the ground floor.
    function automatic logic [2:0] norm_floor(input logic [2:0] f);
        logic [2:0] r;
        if (f == 3'd0) begin
            r = 3'd1;
        end else begin
            r = f;
        end
        return r;
    endfunction

    function automatic logic [3:0] floor_dist(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] r;
        if (a >= b) begin
            r = {1'b0, a} - {1'b0, b};
        end else begin
            r = {1'b0, b} - {1'b0, a};
        end
        return r;
    endfunction

endpackage

// File: rtl/hall_call_pick.sv
// Combinational hall-call selector: picks the pending call the car should be offered
// next given its current floor and direction of travel.
module hall_call_pick
    import elevator_pkg::*;
(
    input  logic [6:1] pend_up_i,
    input  logic [7:2] pend_dn_i,
    input  logic [2:0] floor_i,
    input  logic [1:0] dir_i,
    output logic [2:0] floor_o,
    output logic [1:0] dir_o,
    output logic       valid_o
);

    logic [7:0] up_s;
    logic [7:0] dn_s;
    logic [2:0] car_s;
    logic [2:0] cand_s;
    logic [3:0] dist_s;
    logic [3:0] best_dist_s;
    logic       up_ok_s;
    logic       dn_ok_s;

    assign up_s  = {1'b0, pend_up_i, 1'b0};
    assign dn_s  = {pend_dn_i, 2'b00};
    assign car_s = norm_floor(floor_i);

    // Ascending scan keeping only strict improvements: equal distances keep the lower
    // floor, and UP (tested first) beats DOWN at the same floor.
    always_comb begin
        floor_o     = FLOOR_NONE;
        dir_o       = DIR_IDLE;
        valid_o     = 1'b0;
        best_dist_s = 4'hF;
        cand_s      = 3'd0;
        dist_s      = 4'd0;
        up_ok_s     = 1'b0;
        dn_ok_s     = 1'b0;
        for (int f = 0; f <= NUM_FLOOR; f++) begin
            cand_s  = 3'(f);
            dist_s  = floor_dist(cand_s, car_s);
            up_ok_s = (dir_i == UP)   ? (cand_s >= car_s) : (dir_i != DOWN);
            dn_ok_s = (dir_i == DOWN) ? (cand_s <= car_s) : (dir_i != UP);
            if (up_s[f] && up_ok_s && (dist_s < best_dist_s)) begin
                best_dist_s = dist_s;
                floor_o     = cand_s;
                dir_o       = UP;
                valid_o     = 1'b1;
            end else if (dn_s[f] && dn_ok_s && (dist_s < best_dist_s)) begin
                best_dist_s = dist_s;
                floor_o     = cand_s;
                dir_o       = DOWN;
                valid_o     = 1'b1;
            end else begin
                best_dist_s = best_dist_s;
            end
        end
    end

endmodule

// File: rtl/hall_call_arbiter.sv
// Hall-call arbiter: latches landing buttons until serviced, drives the hall lamps and
// offers one pending call at a time to the car controller.
module hall_call_arbiter
    import elevator_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:1] HallUp,
    input  logic [7:2] HallDown,
    input  logic [2:0] FloorOut,
    input  logic [1:0] DirectOut,
    input  logic       DoorOut,
    output logic [2:0] TargetFloor,
    output logic [1:0] TargetDirect,
    output logic [6:1] LampUp,
    output logic [7:2] LampDown
);

    arb_state_t state_q, state_d;
    logic [6:1] pend_up_q, pend_up_d;
    logic [7:2] pend_dn_q, pend_dn_d;
    logic [2:0] tgt_floor_q, tgt_floor_d;
    logic [1:0] tgt_dir_q, tgt_dir_d;

    logic [2:0] car_s;
    logic [6:1] clr_up_s;
    logic [7:2] clr_dn_s;
    logic       clr_up_dir_s;
    logic       clr_dn_dir_s;
    logic [2:0] pick_floor_s;
    logic [1:0] pick_dir_s;
    logic       pick_valid_s;
    logic       svc_hit_s;
    logic       between_s;
    logic       pickup_s;

    assign car_s        = norm_floor(FloorOut);
    assign clr_up_dir_s = DoorOut && ((DirectOut == UP) || (DirectOut == DIR_IDLE));
    assign clr_dn_dir_s = DoorOut && ((DirectOut == DOWN) || (DirectOut == DIR_IDLE));

    // Service-event decode: one-hot clear masks for the car's current landing.
    always_comb begin
        clr_up_s = 6'd0;
        clr_dn_s = 6'd0;
        for (int f = 1; f <= 6; f++) begin
            clr_up_s[f] = clr_up_dir_s && (car_s == 3'(f));
        end
        for (int f = 2; f <= 7; f++) begin
            clr_dn_s[f] = clr_dn_dir_s && (car_s == 3'(f));
        end
    end

    // Clear is applied after set so a press at an open door is absorbed.
    assign pend_up_d = (pend_up_q | HallUp) & ~clr_up_s;
    assign pend_dn_d = (pend_dn_q | HallDown) & ~clr_dn_s;

    hall_call_pick u_pick (
        .pend_up_i (pend_up_q),
        .pend_dn_i (pend_dn_q),
        .floor_i   (FloorOut),
        .dir_i     (DirectOut),
        .floor_o   (pick_floor_s),
        .dir_o     (pick_dir_s),
        .valid_o   (pick_valid_s)
    );

    assign svc_hit_s = DoorOut && (car_s == tgt_floor_q) &&
                       ((DirectOut == tgt_dir_q) || (DirectOut == DIR_IDLE));
    assign between_s = (DirectOut == UP)   ? ((pick_floor_s > car_s) && (pick_floor_s < tgt_floor_q)) :
                       (DirectOut == DOWN) ? ((pick_floor_s < car_s) && (pick_floor_s > tgt_floor_q)) :
                                             1'b0;
    // No retarget while a door is open so the target never moves on a service-clear cycle.
    assign pickup_s  = !DoorOut && pick_valid_s && (pick_dir_s == DirectOut) && between_s;

    // Next-state and target selection.
    always_comb begin
        state_d     = state_q;
        tgt_floor_d = tgt_floor_q;
        tgt_dir_d   = tgt_dir_q;
        case (state_q)
            ST_IDLE, ST_SERVE: begin
                if (pick_valid_s) begin
                    state_d     = ST_HOLD;
                    tgt_floor_d = pick_floor_s;
                    tgt_dir_d   = pick_dir_s;
                end else begin
                    state_d     = ST_IDLE;
                    tgt_floor_d = FLOOR_NONE;
                    tgt_dir_d   = DIR_IDLE;
                end
            end
            ST_HOLD: begin
                if (svc_hit_s) begin
                    state_d     = ST_SERVE;
                    tgt_floor_d = FLOOR_NONE;
                    tgt_dir_d   = DIR_IDLE;
                end else if (pickup_s) begin
                    state_d     = ST_HOLD;
                    tgt_floor_d = pick_floor_s;
                    tgt_dir_d   = pick_dir_s;
                end else begin
                    state_d     = ST_HOLD;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                tgt_floor_d = FLOOR_NONE;
                tgt_dir_d   = DIR_IDLE;
            end
        endcase
    end

    // State, pending and target registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            pend_up_q   <= 6'd0;
            pend_dn_q   <= 6'd0;
            tgt_floor_q <= FLOOR_NONE;
            tgt_dir_q   <= DIR_IDLE;
        end else begin
            state_q     <= state_d;
            pend_up_q   <= pend_up_d;
            pend_dn_q   <= pend_dn_d;
            tgt_floor_q <= tgt_floor_d;
            tgt_dir_q   <= tgt_dir_d;
        end
    end

    assign TargetFloor  = tgt_floor_q;
    assign TargetDirect = tgt_dir_q;
    assign LampUp       = pend_up_q;
    assign LampDown     = pend_dn_q;

endmodule

// File: tb/tb_hall_call_arbiter.sv
// Directed bench for hall_call_arbiter: a call-list model checked every cycle plus
// hand-computed expectations at key points of each scenario.
module tb_hall_call_arbiter;

    logic       clk;
    logic       reset;
    logic [6:1] HallUp;
    logic [7:2] HallDown;
    logic [2:0] FloorOut;
    logic [1:0] DirectOut;
    logic       DoorOut;
    logic [2:0] TargetFloor;
    logic [1:0] TargetDirect;
    logic [6:1] LampUp;
    logic [7:2] LampDown;

    int total = 0;
    int bad   = 0;

    hall_call_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .HallUp       (HallUp),
        .HallDown     (HallDown),
        .FloorOut     (FloorOut),
        .DirectOut    (DirectOut),
        .DoorOut      (DoorOut),
        .TargetFloor  (TargetFloor),
        .TargetDirect (TargetDirect),
        .LampUp       (LampUp),
        .LampDown     (LampDown)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model: pending call bits indexed by floor, one offered target
    logic [7:0] m_up, m_dn, n_up, n_dn;
    int         m_tf, n_tf, fl, pk, p_floor;
    logic [1:0] m_td, n_td, p_dir;

    function automatic int tb_norm(input logic [2:0] f);
        return (f == 3'd0) ? 1 : int'(f);
    endfunction

    // Returns floor*4 + direction code, 0 when nothing qualifies.
    function automatic int tb_pick(input logic [7:0] up, input logic [7:0] dn,
                                   input int cf, input logic [1:0] d);
        int lo, hi;
        if (d == 2'b10) begin
            for (int f = cf; f <= 6; f++) if (up[f]) return f * 4 + 2;
            return 0;
        end
        if (d == 2'b01) begin
            for (int f = cf; f >= 2; f--) if (dn[f]) return f * 4 + 1;
            return 0;
        end
        for (int k = 0; k <= 6; k++) begin
            lo = cf - k;
            hi = cf + k;
            if (lo >= 1) begin
                if (up[lo]) return lo * 4 + 2;
                if (dn[lo]) return lo * 4 + 1;
            end
            if (k > 0 && hi <= 7) begin
                if (up[hi]) return hi * 4 + 2;
                if (dn[hi]) return hi * 4 + 1;
            end
        end
        return 0;
    endfunction

    always_comb begin
        fl      = tb_norm(FloorOut);
        pk      = tb_pick(m_up, m_dn, fl, DirectOut);
        p_floor = pk / 4;
        p_dir   = 2'(pk % 4);
        n_up    = m_up | {1'b0, HallUp, 1'b0};
        n_dn    = m_dn | {HallDown, 2'b00};
        if (DoorOut && (DirectOut == 2'b10 || DirectOut == 2'b00)) n_up[fl] = 1'b0;
        if (DoorOut && (DirectOut == 2'b01 || DirectOut == 2'b00)) n_dn[fl] = 1'b0;
        n_tf = m_tf;
        n_td = m_td;
        if (m_tf == 0) begin
            n_tf = p_floor;
            n_td = p_dir;
        end else if (DoorOut && fl == m_tf && (DirectOut == m_td || DirectOut == 2'b00)) begin
            n_tf = 0;
            n_td = 2'b00;
        end else if (!DoorOut && p_floor != 0 && p_dir == DirectOut &&
                     ((DirectOut == 2'b10 && p_floor > fl && p_floor < m_tf) ||
                      (DirectOut == 2'b01 && p_floor < fl && p_floor > m_tf))) begin
            n_tf = p_floor;
            n_td = p_dir;
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_up <= 8'd0;
            m_dn <= 8'd0;
            m_tf <= 0;
            m_td <= 2'b00;
        end else begin
            m_up <= n_up;
            m_dn <= n_dn;
            m_tf <= n_tf;
            m_td <= n_td;
        end
    end

    always @(negedge clk) begin
        chk("cyc_tgt_floor", {29'd0, TargetFloor}, m_tf);
        chk("cyc_tgt_dir", {30'd0, TargetDirect}, {30'd0, m_td});
        chk("cyc_lamp_up", {26'd0, LampUp}, {26'd0, m_up[6:1]});
        chk("cyc_lamp_dn", {26'd0, LampDown}, {26'd0, m_dn[7:2]});
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic expect_tgt(input string nm, input int f, input int d);
        chk({nm, "_floor"}, {29'd0, TargetFloor}, f);
        chk({nm, "_dir"}, {30'd0, TargetDirect}, d);
    endtask

    initial begin
        reset = 1'b1; HallUp = 6'd0; HallDown = 6'd0;
        FloorOut = 3'd4; DirectOut = 2'b00; DoorOut = 1'b0;
        #1 reset = 1'b0;
        tick(); tick();
        expect_tgt("reset", 0, 0);
        chk("reset_lamps", {20'd0, LampUp, LampDown}, 32'd0);
        reset = 1'b1;
        tick();

        // idle at 4: down6 vs up2 tie at distance 2, lower floor wins
        HallDown[6] = 1'b1; HallUp[2] = 1'b1;
        tick();
        HallDown[6] = 1'b0; HallUp[2] = 1'b0;
        chk("idle_lamp_up", {26'd0, LampUp}, 32'b000010);
        chk("idle_lamp_dn", {26'd0, LampDown}, 32'b010000);
        expect_tgt("idle_wait", 0, 0);
        tick();
        expect_tgt("idle_pick", 2, 2);
        FloorOut = 3'd2; DoorOut = 1'b1;
        tick();
        DoorOut = 1'b0;
        expect_tgt("idle_serve_gap", 0, 0);
        tick();
        expect_tgt("idle_next", 6, 1);
        FloorOut = 3'd6; DirectOut = 2'b01; DoorOut = 1'b1;
        tick();
        DoorOut = 1'b0; DirectOut = 2'b00;
        tick();

        // moving up from 2 toward 6 UP: down3 ignored, up4 picked up
        FloorOut = 3'd2; DirectOut = 2'b10; HallUp[6] = 1'b1;
        tick();
        HallUp[6] = 1'b0;
        tick();
        expect_tgt("pickup_base", 6, 2);
        HallDown[3] = 1'b1;
        tick();
        HallDown[3] = 1'b0;
        tick();
        expect_tgt("pickup_ignore_dn", 6, 2);
        chk("pickup_lamp_dn3", {26'd0, LampDown}, 32'b000010);
        HallUp[4] = 1'b1;
        tick();
        HallUp[4] = 1'b0;
        expect_tgt("pickup_lamp_edge", 6, 2);
        tick();
        expect_tgt("pickup_retarget", 4, 2);
        FloorOut = 3'd4; DoorOut = 1'b1;
        tick();
        DoorOut = 1'b0;
        tick();
        expect_tgt("pickup_resume", 6, 2);
        FloorOut = 3'd6; DoorOut = 1'b1;
        tick();
        DoorOut = 1'b0; DirectOut = 2'b01;
        tick();
        expect_tgt("pickup_down_leg", 3, 1);
        FloorOut = 3'd3; DoorOut = 1'b1;
        tick();
        DoorOut = 1'b0; DirectOut = 2'b00;
        tick();

        // both calls at 5: UP first, DOWN survives the UP service
        FloorOut = 3'd1; HallUp[5] = 1'b1; HallDown[5] = 1'b1;
        tick();
        HallUp[5] = 1'b0; HallDown[5] = 1'b0;
        tick();
        expect_tgt("svc_first", 5, 2);
        FloorOut = 3'd5; DirectOut = 2'b10; DoorOut = 1'b1;
        tick();
        DoorOut = 1'b0; DirectOut = 2'b00;
        expect_tgt("svc_gap", 0, 0);
        chk("svc_lamp_up", {26'd0, LampUp}, 32'd0);
        chk("svc_lamp_dn5", {26'd0, LampDown}, 32'b001000);
        tick();
        expect_tgt("svc_second", 5, 1);
        DoorOut = 1'b1;
        tick();
        DoorOut = 1'b0;
        tick();

        // press while door open at 3 going up is absorbed
        FloorOut = 3'd3; DirectOut = 2'b10; DoorOut = 1'b1; HallUp[3] = 1'b1;
        tick(); tick();
        chk("absorb_lamp", {26'd0, LampUp}, 32'd0);
        HallUp[3] = 1'b0; DoorOut = 1'b0; DirectOut = 2'b00;
        tick();
        HallUp[3] = 1'b1;
        tick();
        HallUp[3] = 1'b0;
        chk("absorb_relatch", {26'd0, LampUp}, 32'b000100);
        tick();
        expect_tgt("absorb_tgt", 3, 2);
        DoorOut = 1'b1;
        tick();
        DoorOut = 1'b0;
        tick();

        // end floors from 7: 7 DOWN then 1 UP
        FloorOut = 3'd7; HallDown[7] = 1'b1; HallUp[1] = 1'b1;
        tick();
        HallDown[7] = 1'b0; HallUp[1] = 1'b0;
        tick();
        expect_tgt("edge_top", 7, 1);
        DoorOut = 1'b1;
        tick();
        DoorOut = 1'b0;
        chk("edge_lamps", {20'd0, LampUp, LampDown}, 32'b000001_000000);
        tick();
        expect_tgt("edge_bottom", 1, 2);

        // FloorOut 0 acts as floor 1 for service and for distance
        FloorOut = 3'd0; DoorOut = 1'b1;
        tick();
        DoorOut = 1'b0;
        expect_tgt("f0_serve", 0, 0);
        chk("f0_lamp", {26'd0, LampUp}, 32'd0);
        tick();
        HallUp[2] = 1'b1; HallDown[5] = 1'b1;
        tick();
        HallUp[2] = 1'b0; HallDown[5] = 1'b0;
        tick();
        expect_tgt("f0_pick", 2, 2);
        HallDown[4] = 1'b1;
        tick();
        HallDown[4] = 1'b0;

        // asynchronous reset in HOLD drops everything immediately
        #2 reset = 1'b0;
        #1;
        expect_tgt("async_reset", 0, 0);
        chk("async_reset_lamps", {20'd0, LampUp, LampDown}, 32'd0);
        tick();
        reset = 1'b1;
        tick(); tick();
        expect_tgt("post_reset", 0, 0);
        chk("post_reset_lamps", {20'd0, LampUp, LampDown}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
